des_perm_pipe: RTL and testbench
================================

Name: des_perm_pipe

Overview:
- Parametrised, pipelined DES bit-permutation unit.
- Applies the initial permutation (IP) or the final permutation (FP = IP⁻¹) to LANES independent 64-bit blocks per beat, selected per beat.
- Uses a valid/ready handshake with full backpressure, plus an optional L/R half-swap ahead of FP.
- Sits between the plaintext/ciphertext interface and the round engine (IP), and between the round engine and the output (FP).

Parameters:
- LANES, 1: number of 64-bit blocks per beat; data buses are 64*LANES wide.
- PIPE_STAGES, 1: register stages from input to output, legal range 1..4.
- TAG_W, 4: width of the sideband tag carried alongside each beat.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- clear  in  1  synchronous flush; drops all in-flight beats.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_mode  in  1  0 = IP, 1 = FP.
- in_swap  in  1  1 = exchange 32-bit halves of each lane before permuting; honoured only when in_mode = 1.
- in_tag  in  TAG_W  sideband, returned unchanged.
- in_data  in  64*LANES  lane k occupies bits [64k+63:64k]; in each lane, MSB = DES bit 1.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_mode  out  1  mode of the output beat.
- out_tag  out  TAG_W  tag of the output beat.
- out_data  out  64*LANES  permuted data.
- occupancy  out  3  number of valid beats in the pipeline, 0..PIPE_STAGES.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. On reset:
  - all stage valid bits = 0; out_valid = 0.
  - out_data = 0, out_tag = 0, out_mode = 0.
  - occupancy = 0; in_ready = 1 immediately after reset deasserts.
- Permutation:
  - Combinational on the input side, registered into stage 1. Stages 2..PIPE_STAGES are pure delay.
  - IP: out bit j = in bit IP[j], standard DES table (58, 50, 42, …, 7).
  - FP: out bit j = in bit FP[j], standard DES table (40, 8, 48, …, 25).
  - Swap, when active, is applied before FP: {L,R} -> {R,L}.
  - Each lane is permuted identically and independently.
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - Stage k holds its value while stage k is valid and cannot advance.
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances when out_ready = 1.
  - in_ready = !v[1] || stage 1 advancing. Combinational, no dependence on in_valid.
  - Bubbles collapse: an empty stage accepts from the stage before it regardless of stages further downstream.
  - Unstalled latency = PIPE_STAGES cycles from input transfer to out_valid.
  - Throughput: 1 beat/cycle while out_ready = 1.
- Stall rules:
  - out_data, out_tag and out_mode stay stable while out_valid && !out_ready.
  - Registers of invalid stages keep stale data; only out_valid qualifies the outputs.
- occupancy:
  - Registered count of valid stages.
  - Updates each cycle: +1 on an input transfer, −1 on an output transfer, unchanged when both occur together.
- clear:
  - Next edge: all valid bits = 0, occupancy = 0. An input beat offered in the same cycle is dropped.
  - in_ready stays per the formula above; out_valid is 0 from the next cycle.
- Reset mid-operation: all in-flight beats are lost. No partial output is produced.
- in_mode, in_swap and in_tag are sampled only on an input transfer.

Test Plan:
- LANES = 1, PIPE_STAGES = 1, mode = IP, data 0x0123456789ABCDEF -> out_data 0xCC00CCFFF0AAF0AA one cycle later; occupancy 1 then 0.
- mode = FP, swap = 0, data 0xCC00CCFFF0AAF0AA -> 0x0123456789ABCDEF. Then mode = FP, swap = 1, data 0x43423234_0A4CD995 -> 0x85E813540F0AB405.
- LANES = 2, PIPE_STAGES = 3, back-to-back stream of 8 beats, tags 0..7, alternating modes, out_ready = 1 -> first output at cycle 3, 8 consecutive outputs, tags in order, each lane correct.
- PIPE_STAGES = 3, hold out_ready = 0 for 5 cycles during the stream -> occupancy reaches 3, in_ready = 0, held out_data stable, no beat lost or duplicated after release.
- Pulse clear with occupancy 2 and in_valid = 1 -> next cycle occupancy 0, out_valid 0, the offered beat never appears. Assert rst_n low mid-stream -> all outputs 0, in_ready 1 after release.
- Simultaneous in/out transfer with a full pipeline and out_ready = 1 -> occupancy unchanged, in_ready = 1, full throughput sustained.

Source files
------------

// File: rtl/des_perm_pipe.sv
// des_perm_pipe: pipelined DES IP/FP bit permutation over LANES 64-bit blocks,
// with valid/ready flow control, bubble collapsing and an optional L/R swap
// ahead of FP. The permutation is combinational on the input side and is
// registered into stage 0; later stages only delay the beat.
// PIPE_STAGES is legal from 1 to 4 (occupancy is 3 bits wide).
module des_perm_pipe #(
    parameter int LANES       = 1,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic                  in_swap,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic [64*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic [TAG_W-1:0]      out_tag,
    output logic [64*LANES-1:0]   out_data,
    output logic [2:0]            occupancy
);

    localparam int DW   = 64 * LANES;
    localparam int LAST = PIPE_STAGES - 1;

    // Standard DES tables, 1-based source bit numbers with bit 1 = MSB.
    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    logic [DW-1:0]          w_src;
    logic [DW-1:0]          w_ip;
    logic [DW-1:0]          w_fp;
    logic [DW-1:0]          w_perm;
    logic                   w_swap;
    logic [PIPE_STAGES-1:0] w_load;
    logic                   w_in_xfer;
    logic                   w_out_xfer;

    logic [PIPE_STAGES-1:0] r_valid;
    logic [PIPE_STAGES-1:0] r_mode;
    logic [DW-1:0]          r_data [PIPE_STAGES];
    logic [TAG_W-1:0]       r_tag  [PIPE_STAGES];
    logic [2:0]             r_occ;

    // The half swap only matters on the FP path; IP ignores in_swap.
    assign w_swap = in_mode && in_swap;

    genvar gl, gi;
    generate
        for (gl = 0; gl < LANES; gl++) begin : g_lane
            // {L,R} -> {R,L} when swapping, otherwise pass the lane through.
            assign w_src[64*gl +: 64] = w_swap ? {in_data[64*gl +: 32], in_data[64*gl+32 +: 32]}
                                               : in_data[64*gl +: 64];
            for (gi = 0; gi < 64; gi++) begin : g_bit
                // Output DES bit gi+1 sits at vector bit 63-gi; source bit n sits at 64-n.
                assign w_ip[64*gl + 63 - gi] = w_src[64*gl + 64 - IP_TAB[gi]];
                assign w_fp[64*gl + 63 - gi] = w_src[64*gl + 64 - FP_TAB[gi]];
            end
        end
    endgenerate

    assign w_perm = in_mode ? w_fp : w_ip;

    // Walk from the output backwards: a stage may load when it is empty or when
    // something downstream (an empty stage or the consumer) makes room.
    always_comb begin : proc_flow
        logic w_room;
        w_room = out_ready;
        w_load = '0;
        for (int k = LAST; k >= 0; k--) begin
            w_room    = w_room || !r_valid[k];
            w_load[k] = w_room;
        end
    end

    assign in_ready   = w_load[0];
    assign w_in_xfer  = in_valid && w_load[0];
    assign w_out_xfer = r_valid[LAST] && out_ready;

    // Stage valid bits: shift forward on load, flushed entirely by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (clear) begin
            r_valid <= '0;
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= in_valid;
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= r_valid[k-1];
                end
            end
        end
    end

    // Payload registers: only written when a real beat moves in, so empty
    // stages keep stale contents and a stalled output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                r_data[k] <= '0;
                r_tag[k]  <= '0;
            end
        end else begin
            if (w_in_xfer) begin
                r_data[0] <= w_perm;
                r_tag[0]  <= in_tag;
                r_mode[0] <= in_mode;
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (w_load[k] && r_valid[k-1]) begin
                    r_data[k] <= r_data[k-1];
                    r_tag[k]  <= r_tag[k-1];
                    r_mode[k] <= r_mode[k-1];
                end
            end
        end
    end

    // Beat count: simultaneous in and out transfers cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (clear) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + {2'b00, w_in_xfer} - {2'b00, w_out_xfer};
        end
    end

    assign out_valid = r_valid[LAST];
    assign out_mode  = r_mode[LAST];
    assign out_tag   = r_tag[LAST];
    assign out_data  = r_data[LAST];
    assign occupancy = r_occ;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Testbench for des_perm_pipe (LANES=2, PIPE_STAGES=3): known-answer vectors,
// a tagged stream, stalls, clear, mid-stream reset and a randomized phase,
// all scored against a queue-based reference model.
module tb_des_perm_pipe;

    localparam int LANES = 2;
    localparam int P     = 3;
    localparam int TAG_W = 4;
    localparam int DW    = 64 * LANES;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic             in_swap;
    logic [TAG_W-1:0] in_tag;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_mode;
    logic [TAG_W-1:0] out_tag;
    logic [DW-1:0]    out_data;
    logic [2:0]       occupancy;

    des_perm_pipe #(.LANES(LANES), .PIPE_STAGES(P), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_swap(in_swap), .in_tag(in_tag), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_tag(out_tag), .out_data(out_data), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]    data;
        logic [TAG_W-1:0] tag;
        logic             mode;
        int               entry;
    } beat_t;

    beat_t            q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    int               last_pop = -100;
    logic             stall_prev = 1'b0;
    logic [DW-1:0]    held_data;
    logic [TAG_W-1:0] held_tag;
    logic             held_mode;
    logic [DW-1:0]    last_out;
    logic             saw_full = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: IP straight from the table, FP as the inverse mapping of IP.
    function automatic logic [63:0] perm64(input logic [63:0] x, input logic md, input logic sw);
        logic [63:0] s;
        logic [63:0] r;
        s = (md && sw) ? {x[31:0], x[63:32]} : x;
        r = '0;
        for (int j = 1; j <= 64; j++) begin
            if (!md) r[64 - j] = s[64 - IP_T[j-1]];
            else     r[64 - IP_T[j-1]] = s[64 - j];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic md, input logic sw);
        return {perm64(d[127:64], md, sw), perm64(d[63:0], md, sw)};
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, score the edge.
    task automatic cycle(input logic vld, input logic md, input logic sw, input logic [TAG_W-1:0] tg,
                         input logic [DW-1:0] dat, input logic ordy, input logic clr, output logic acc);
        beat_t b;
        int    avail;
        logic  exp_ov;
        in_valid = vld; in_mode = md; in_swap = sw; in_tag = tg; in_data = dat;
        out_ready = ordy; clear = clr;
        #1;
        check("occupancy", 128'(occupancy), 128'(q.size()));
        check("in_ready", 128'(in_ready), 128'((q.size() < P) || ordy));
        exp_ov = 1'b0;
        if (q.size() > 0) begin
            avail = q[0].entry + P;
            if (last_pop + 1 > avail) avail = last_pop + 1;
            exp_ov = (cyc >= avail);
        end
        check("out_valid", 128'(out_valid), 128'(exp_ov));
        if (occupancy == 3'(P) && !in_ready) saw_full = 1'b1;
        if (stall_prev && out_valid) begin
            check("hold_data", out_data, held_data);
            check("hold_tag", 128'(out_tag), 128'(held_tag));
            check("hold_mode", 128'(out_mode), 128'(held_mode));
        end
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                check("spurious_beat", 128'(1), 128'(0));
            end else begin
                b = q.pop_front();
                $display("out cyc=%0d tag=%0d mode=%0d data=%h", cyc, out_tag, out_mode, out_data);
                check("out_data", out_data, b.data);
                check("out_tag", 128'(out_tag), 128'(b.tag));
                check("out_mode", 128'(out_mode), 128'(b.mode));
                last_pop = cyc;
                last_out = out_data;
            end
        end
        stall_prev = out_valid && !ordy;
        held_data = out_data; held_tag = out_tag; held_mode = out_mode;
        acc = vld && in_ready;
        if (clr) begin
            q.delete();
        end else if (acc) begin
            b.data = model(dat, md, sw); b.tag = tg; b.mode = md; b.entry = cyc;
            q.push_back(b);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    // Send n beats honouring backpressure; out_ready drops for stall_len cycles from stall_at.
    task automatic run_stream(input int n, input int stall_at, input int stall_len, input bit rnd_mode);
        int               sent = 0;
        int               t = 0;
        logic             acc, md, sw, ordy;
        logic [DW-1:0]    d;
        d  = {$urandom, $urandom, $urandom, $urandom};
        md = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        sw = 1'($urandom_range(0, 1));
        while (sent < n && t < 1000) begin
            ordy = !(t >= stall_at && t < stall_at + stall_len);
            cycle(1'b1, md, sw, TAG_W'(sent), d, ordy, 1'b0, acc);
            if (acc) begin
                sent++;
                d  = {$urandom, $urandom, $urandom, $urandom};
                md = rnd_mode ? 1'($urandom_range(0, 1)) : 1'(sent % 2);
                sw = 1'($urandom_range(0, 1));
            end
            t++;
        end
        check("stream_sent", 128'(sent), 128'(n));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        check("drained", 128'(q.size()), 128'(0));
        idle(2);
    endtask

    task automatic mid_reset();
        in_valid = 1'b0; clear = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_tag", 128'(out_tag), 128'(0));
        check("rst_out_mode", 128'(out_mode), 128'(0));
        check("rst_occupancy", 128'(occupancy), 128'(0));
        q.delete(); stall_prev = 1'b0; last_pop = -100;
        @(posedge clk); cyc++; #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
    endtask

    initial begin : main
        logic acc;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_swap = 1'b0;
        in_tag = '0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out_data", out_data, '0);
        check("reset_out_tag", 128'(out_tag), 128'(0));
        check("reset_out_mode", 128'(out_mode), 128'(0));
        check("reset_occupancy", 128'(occupancy), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1));

        // Known answers; IP must ignore the swap request.
        cycle(1'b1, 1'b0, 1'b1, 4'd1, {2{64'h0123456789ABCDEF}}, 1'b1, 1'b0, acc);
        idle(P + 1);
        check("kat_ip", last_out, {2{64'hCC00CCFFF0AAF0AA}});
        cycle(1'b1, 1'b1, 1'b0, 4'd2, {2{64'hCC00CCFFF0AAF0AA}}, 1'b1, 1'b0, acc);
        idle(P + 1);
        check("kat_fp", last_out, {2{64'h0123456789ABCDEF}});
        cycle(1'b1, 1'b1, 1'b1, 4'd3, {2{64'h434232340A4CD995}}, 1'b1, 1'b0, acc);
        idle(P + 1);
        check("kat_fp_swap", last_out, {2{64'h85E813540F0AB405}});

        // Back-to-back tagged stream with alternating modes, then a stalled stream.
        run_stream(8, 1000, 0, 1'b0);
        drain();
        saw_full = 1'b0;
        run_stream(12, 3, 5, 1'b1);
        check("stall_filled", 128'(saw_full), 128'(1));
        drain();

        // Clear with two beats in flight and a beat offered in the same cycle.
        cycle(1'b1, 1'b0, 1'b0, 4'd4, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, acc);
        cycle(1'b1, 1'b1, 1'b0, 4'd5, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, acc);
        check("pre_clear_occ", 128'(occupancy), 128'(2));
        cycle(1'b1, 1'b0, 1'b0, 4'hA, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, acc);
        check("clear_occ", 128'(occupancy), 128'(0));
        check("clear_out_valid", 128'(out_valid), 128'(0));
        idle(P + 2);

        // Long full-throughput stream, then reset in the middle of another one.
        run_stream(20, 1000, 0, 1'b1);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 1'b1, TAG_W'(i), {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, acc);
        mid_reset();
        idle(P + 2);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  TAG_W'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 49) == 0), acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
